// File: rtl/retire_wide_if.sv
// retire_wide_if
//   Store-commit memory port of the retire stage. Retired stores leave the
//   internal store FIFO through this valid/ready handshake.
//
//   Signals:
//     st_valid  FIFO head holds a committed store
//     st_ready  memory accepts the store at the head this cycle
//     st_tag    ROB tag of the store at the FIFO head
//     st_size   store size in bytes (1/2/4/8)
//
//   Modports:
//     master  the retire stage (drives valid/tag/size, samples ready)
//     slave   the memory side (drives ready)
interface retire_wide_if #(
  parameter int TAG_W = 6
) ();

  logic             st_valid;
  logic             st_ready;
  logic [TAG_W-1:0] st_tag;
  logic [3:0]       st_size;

  modport master (
    output st_valid,
    output st_tag,
    output st_size,
    input  st_ready
  );

  modport slave (
    input  st_valid,
    input  st_tag,
    input  st_size,
    output st_ready
  );

endinterface

// File: rtl/retire_wide.sv
// retire_wide
//   In-order commit stage. Each cycle it retires the longest ready prefix of
//   the WIDTH oldest ROB entries (slot 0 is the oldest), writes their results
//   to the architectural register file, pops the ROB and LSQ, queues at most
//   one retired store into a small store-commit FIFO, and sequences
//   jump/mispredict redirects through a RUN -> FLUSH -> RECOVER machine.
//
//   Ports:
//     clk            clock, all state updates on the rising edge
//     reset          asynchronous, active-low reset
//     retire_stall   blocks all retirement this cycle
//     head_*         per-slot ROB head entry fields (ready, tag, rd, value,
//                    pc, regwr, store, jalr, mispredict, st_size)
//     rob_pop        number of entries retired this cycle (combinational)
//     lsq_pop        LSQ head popped this cycle (combinational)
//     rf_we/rd/value registered register-file write port, one per slot
//     st_port        store-commit memory handshake (retire_wide_if.master)
//     flush          one-cycle redirect pulse
//     jump_to        redirect target, meaningful while flush is high
//     retired_cnt    running count of retired instructions (wraps)
module retire_wide #(
  parameter int WIDTH    = 2,
  parameter int TAG_W    = 6,
  parameter int XLEN     = 64,
  parameter int SQ_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         retire_stall,
  input  logic [WIDTH-1:0]             head_ready,
  input  logic [WIDTH*TAG_W-1:0]       head_tag,
  input  logic [WIDTH*5-1:0]           head_rd,
  input  logic [WIDTH*XLEN-1:0]        head_value,
  input  logic [WIDTH*XLEN-1:0]        head_pc,
  input  logic [WIDTH-1:0]             head_regwr,
  input  logic [WIDTH-1:0]             head_store,
  input  logic [WIDTH-1:0]             head_jalr,
  input  logic [WIDTH-1:0]             head_mispredict,
  input  logic [WIDTH*4-1:0]           head_st_size,
  output logic [$clog2(WIDTH+1)-1:0]   rob_pop,
  output logic                         lsq_pop,
  output logic [WIDTH-1:0]             rf_we,
  output logic [WIDTH*5-1:0]           rf_rd,
  output logic [WIDTH*XLEN-1:0]        rf_value,
  retire_wide_if.master                st_port,
  output logic                         flush,
  output logic [XLEN-1:0]              jump_to,
  output logic [63:0]                  retired_cnt
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PTR_W = $clog2(SQ_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_RECOVER
  } state_t;

  state_t state_q;
  state_t state_d;

  // Retire decision signals
  logic [WIDTH-1:0] retire;
  logic             store_hit;
  logic [TAG_W-1:0] push_tag;
  logic [3:0]       push_size;
  logic             redir_hit;
  logic [XLEN-1:0]  redir_target;

  // Store-commit FIFO storage and bookkeeping
  logic [TAG_W-1:0] sq_tag  [SQ_DEPTH];
  logic [3:0]       sq_size [SQ_DEPTH];
  logic [PTR_W-1:0] sq_wr_ptr;
  logic [PTR_W-1:0] sq_rd_ptr;
  logic [PTR_W:0]   sq_count;
  logic             sq_full;
  logic             sq_valid;
  logic             sq_push;
  logic             sq_pop;

  // Fullness is judged on the count at the start of the cycle, so a pop in
  // the same cycle never makes room for a store retiring in that cycle.
  assign sq_full  = (sq_count == (PTR_W+1)'(SQ_DEPTH));
  assign sq_valid = (sq_count != '0);
  assign sq_push  = store_hit;
  assign sq_pop   = sq_valid && st_port.st_ready;

  // Walk the slots oldest-first and retire the longest legal prefix. The
  // walk stops at the first slot that is not ready, at a second store (or a
  // store while the FIFO is full), and right after a redirecting slot.
  always_comb begin
    logic go;
    retire       = '0;
    rob_pop      = '0;
    store_hit    = 1'b0;
    push_tag     = '0;
    push_size    = '0;
    redir_hit    = 1'b0;
    redir_target = '0;
    go           = (state_q == ST_RUN) && !retire_stall;
    for (int i = 0; i < WIDTH; i++) begin
      if (go && head_ready[i] && !(head_store[i] && (store_hit || sq_full))) begin
        retire[i] = 1'b1;
        rob_pop   = rob_pop + CNT_W'(1);
        if (head_store[i]) begin
          store_hit = 1'b1;
          push_tag  = head_tag[i*TAG_W +: TAG_W];
          push_size = head_st_size[i*4 +: 4];
        end
        if (head_jalr[i] || head_mispredict[i]) begin
          redir_hit    = 1'b1;
          redir_target = head_value[i*XLEN +: XLEN];
          go           = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  assign lsq_pop = store_hit;

  // Redirect sequencer: a retired redirect costs one FLUSH cycle (the
  // redirect pulse) and one RECOVER cycle while the ROB/LSQ empty out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:     if (redir_hit) state_d = ST_FLUSH;
      ST_FLUSH:   state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  assign flush = (state_q == ST_FLUSH);

  // Redirect target is captured in the redirect cycle and shown alongside
  // the flush pulse in the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jump_to <= '0;
    end else if (redir_hit) begin
      jump_to <= redir_target;
    end
  end

  // Register-file write port. Enables are recomputed every cycle so they
  // drop to zero after a cycle with no retirement; address/data only move
  // for retiring slots. Jumps write their link address pc+4.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= '0;
      rf_rd    <= '0;
      rf_value <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rf_we[i] <= retire[i] && head_regwr[i] && (head_rd[i*5 +: 5] != 5'd0);
        if (retire[i]) begin
          rf_rd[i*5 +: 5] <= head_rd[i*5 +: 5];
          rf_value[i*XLEN +: XLEN] <= head_jalr[i]
                                      ? head_pc[i*XLEN +: XLEN] + XLEN'(4)
                                      : head_value[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Instruction counter; wraps naturally at 2^64.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt <= '0;
    end else begin
      retired_cnt <= retired_cnt + 64'(rob_pop);
    end
  end

  // Store-commit FIFO. A push can never hit a full FIFO because the retire
  // walk refuses stores while full. Redirects leave it alone so committed
  // stores always reach memory; only reset discards them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq_wr_ptr <= '0;
      sq_rd_ptr <= '0;
      sq_count  <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        sq_tag[i]  <= '0;
        sq_size[i] <= '0;
      end
    end else begin
      if (sq_push) begin
        sq_tag[sq_wr_ptr]  <= push_tag;
        sq_size[sq_wr_ptr] <= push_size;
        sq_wr_ptr          <= sq_wr_ptr + PTR_W'(1);
      end
      if (sq_pop) begin
        sq_rd_ptr <= sq_rd_ptr + PTR_W'(1);
      end
      unique case ({sq_push, sq_pop})
        2'b10:   sq_count <= sq_count + (PTR_W+1)'(1);
        2'b01:   sq_count <= sq_count - (PTR_W+1)'(1);
        default: sq_count <= sq_count;
      endcase
    end
  end

  // Head fields come straight from storage so they hold steady while the
  // memory side back-pressures.
  assign st_port.st_valid = sq_valid;
  assign st_port.st_tag   = sq_tag[sq_rd_ptr];
  assign st_port.st_size  = sq_size[sq_rd_ptr];

endmodule

// File: tb/tb_retire_wide.sv
// tb_retire_wide
//   Bench for retire_wide (WIDTH=2). A behavioural model (slot walk over the
//   commit rules, a queue for the store FIFO, a phase counter for redirects)
//   predicts every output each cycle; directed sequences add literal
//   expectations, followed by randomized traffic.
`timescale 1ns/1ps
module tb_retire_wide;

  localparam int WIDTH    = 2;
  localparam int TAG_W    = 6;
  localparam int XLEN     = 64;
  localparam int SQ_DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic                       retire_stall;
  logic [WIDTH-1:0]           head_ready;
  logic [WIDTH*TAG_W-1:0]     head_tag;
  logic [WIDTH*5-1:0]         head_rd;
  logic [WIDTH*XLEN-1:0]      head_value;
  logic [WIDTH*XLEN-1:0]      head_pc;
  logic [WIDTH-1:0]           head_regwr;
  logic [WIDTH-1:0]           head_store;
  logic [WIDTH-1:0]           head_jalr;
  logic [WIDTH-1:0]           head_mispredict;
  logic [WIDTH*4-1:0]         head_st_size;
  logic [$clog2(WIDTH+1)-1:0] rob_pop;
  logic                       lsq_pop;
  logic [WIDTH-1:0]           rf_we;
  logic [WIDTH*5-1:0]         rf_rd;
  logic [WIDTH*XLEN-1:0]      rf_value;
  logic                       flush;
  logic [XLEN-1:0]            jump_to;
  logic [63:0]                retired_cnt;

  retire_wide_if #(.TAG_W(TAG_W)) st_port ();

  retire_wide #(
    .WIDTH(WIDTH), .TAG_W(TAG_W), .XLEN(XLEN), .SQ_DEPTH(SQ_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .retire_stall(retire_stall),
    .head_ready(head_ready),
    .head_tag(head_tag),
    .head_rd(head_rd),
    .head_value(head_value),
    .head_pc(head_pc),
    .head_regwr(head_regwr),
    .head_store(head_store),
    .head_jalr(head_jalr),
    .head_mispredict(head_mispredict),
    .head_st_size(head_st_size),
    .rob_pop(rob_pop),
    .lsq_pop(lsq_pop),
    .rf_we(rf_we),
    .rf_rd(rf_rd),
    .rf_value(rf_value),
    .st_port(st_port),
    .flush(flush),
    .jump_to(jump_to),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [3:0]       size;
  } st_entry_t;

  int             m_phase = 0;
  st_entry_t      m_q[$];
  logic [WIDTH-1:0] m_we = '0;
  logic [4:0]     m_rd  [WIDTH];
  logic [XLEN-1:0] m_val [WIDTH];
  logic [XLEN-1:0] m_jump = '0;
  logic [63:0]    m_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_phase = 0;
    m_q.delete();
    m_we   = '0;
    m_jump = '0;
    m_cnt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m_rd[i]  = '0;
      m_val[i] = '0;
    end
  endtask

  // Commit rules applied directly to the current head inputs.
  task automatic modelRetire(output int n, output int st_slot, output int rd_slot);
    n = 0;
    st_slot = -1;
    rd_slot = -1;
    if (m_phase != 0 || retire_stall) return;
    for (int i = 0; i < WIDTH; i++) begin
      if (!head_ready[i]) break;
      if (head_store[i] && (st_slot >= 0 || m_q.size() >= SQ_DEPTH)) break;
      n++;
      if (head_store[i]) st_slot = i;
      if (head_jalr[i] || head_mispredict[i]) begin
        rd_slot = i;
        break;
      end
    end
  endtask

  task automatic modelStep();
    int n, ss, rs;
    st_entry_t e;
    modelRetire(n, ss, rs);
    if (m_q.size() != 0 && st_port.st_ready) void'(m_q.pop_front());
    if (ss >= 0) begin
      e.tag  = head_tag[ss*TAG_W +: TAG_W];
      e.size = head_st_size[ss*4 +: 4];
      m_q.push_back(e);
    end
    for (int i = 0; i < WIDTH; i++) begin
      m_we[i] = (i < n) && head_regwr[i] && (head_rd[i*5 +: 5] != 5'd0);
      if (i < n) begin
        m_rd[i]  = head_rd[i*5 +: 5];
        m_val[i] = head_jalr[i] ? head_pc[i*XLEN +: XLEN] + 64'd4
                                : head_value[i*XLEN +: XLEN];
      end
    end
    m_cnt = m_cnt + 64'(n);
    if (m_phase == 0) begin
      if (rs >= 0) begin
        m_phase = 1;
        m_jump  = head_value[rs*XLEN +: XLEN];
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  // Compare every DUT output with the model's prediction for this cycle.
  task automatic checkOutput();
    int n, ss, rs;
    if (!reset) begin
      modelReset();
      chk("rst rf_we", 64'(rf_we), 64'd0);
      chk("rst rf_rd", 64'(rf_rd), 64'd0);
      chk("rst rf_value0", rf_value[63:0], 64'd0);
      chk("rst rf_value1", rf_value[127:64], 64'd0);
      chk("rst st_valid", 64'(st_port.st_valid), 64'd0);
      chk("rst st_tag", 64'(st_port.st_tag), 64'd0);
      chk("rst st_size", 64'(st_port.st_size), 64'd0);
      chk("rst flush", 64'(flush), 64'd0);
      chk("rst jump_to", jump_to, 64'd0);
      chk("rst retired_cnt", retired_cnt, 64'd0);
      return;
    end
    modelRetire(n, ss, rs);
    chk("rob_pop", 64'(rob_pop), 64'(n));
    chk("lsq_pop", 64'(lsq_pop), 64'(ss >= 0));
    chk("rf_we", 64'(rf_we), 64'(m_we));
    for (int i = 0; i < WIDTH; i++) begin
      if (m_we[i]) begin
        chk("rf_rd", 64'(rf_rd[i*5 +: 5]), 64'(m_rd[i]));
        chk("rf_value", rf_value[i*XLEN +: XLEN], m_val[i]);
      end
    end
    chk("st_valid", 64'(st_port.st_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("st_tag", 64'(st_port.st_tag), 64'(m_q[0].tag));
      chk("st_size", 64'(st_port.st_size), 64'(m_q[0].size));
    end
    chk("flush", 64'(flush), 64'(m_phase == 1));
    if (m_phase == 1) chk("jump_to", jump_to, m_jump);
    chk("retired_cnt", retired_cnt, m_cnt);
  endtask

  // Compare process: check after inputs settle, advance model at the edge.
  initial begin : compare_proc
    forever begin
      @(negedge clk);
      #2;
      checkOutput();
      @(posedge clk);
      if (reset) modelStep();
    end
  end

  task automatic clearHeads();
    head_ready = '0; head_tag = '0; head_rd = '0; head_value = '0;
    head_pc = '0; head_regwr = '0; head_store = '0; head_jalr = '0;
    head_mispredict = '0; head_st_size = '0;
  endtask

  task automatic setSlot(input int i, input logic st, input logic jalr, input logic mis,
                         input logic regwr, input logic [4:0] rd, input logic [63:0] val,
                         input logic [63:0] pc, input logic [5:0] tag, input logic [3:0] size);
    head_ready[i]               = 1'b1;
    head_store[i]               = st;
    head_jalr[i]                = jalr;
    head_mispredict[i]          = mis;
    head_regwr[i]               = regwr;
    head_rd[i*5 +: 5]           = rd;
    head_value[i*XLEN +: XLEN]  = val;
    head_pc[i*XLEN +: XLEN]     = pc;
    head_tag[i*TAG_W +: TAG_W]  = tag;
    head_st_size[i*4 +: 4]      = size;
  endtask

  task automatic applyStimulus();
    logic [31:0] r;
    retire_stall     = ($urandom_range(0, 9) == 0);
    st_port.st_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < WIDTH; i++) begin
      head_ready[i]      = ($urandom_range(0, 3) != 0);
      head_store[i]      = ($urandom_range(0, 3) == 0);
      head_jalr[i]       = ($urandom_range(0, 9) == 0);
      head_mispredict[i] = ($urandom_range(0, 11) == 0);
      head_regwr[i]      = ($urandom_range(0, 3) != 0);
      head_rd[i*5 +: 5]  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      head_tag[i*TAG_W +: TAG_W] = TAG_W'($urandom);
      head_value[i*XLEN +: XLEN] = {$urandom, $urandom};
      r = $urandom;
      head_pc[i*XLEN +: XLEN] = {32'h0, r & 32'hFFFF_FFFC};
      case ($urandom_range(0, 3))
        0:       head_st_size[i*4 +: 4] = 4'd1;
        1:       head_st_size[i*4 +: 4] = 4'd2;
        2:       head_st_size[i*4 +: 4] = 4'd4;
        default: head_st_size[i*4 +: 4] = 4'd8;
      endcase
    end
  endtask

  initial begin : stimulus_proc
    clearHeads();
    retire_stall = 1'b0;
    st_port.st_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("lit reset rf_we", 64'(rf_we), 64'd0);
    chk("lit reset st_valid", 64'(st_port.st_valid), 64'd0);
    chk("lit reset retired_cnt", retired_cnt, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Two ready slots, rd=3 and rd=0
    @(negedge clk);
    clearHeads();
    setSlot(0, 0, 0, 0, 1, 5'd3, 64'h11, 64'h0, 6'd1, 4'd0);
    setSlot(1, 0, 0, 0, 1, 5'd0, 64'h22, 64'h4, 6'd2, 4'd0);
    #1 chk("lit both ready rob_pop", 64'(rob_pop), 64'd2);

    // Slot 0 not ready, slot 1 ready
    @(negedge clk);
    clearHeads();
    setSlot(1, 0, 0, 0, 1, 5'd4, 64'h33, 64'h8, 6'd3, 4'd0);
    #1;
    chk("lit rf_we after pair", 64'(rf_we), 64'd1);
    chk("lit rf_rd0", 64'(rf_rd[4:0]), 64'd3);
    chk("lit rf_value0", rf_value[63:0], 64'h11);
    chk("lit cnt after pair", retired_cnt, 64'd2);
    chk("lit blocked rob_pop", 64'(rob_pop), 64'd0);

    // Stall with both slots ready
    @(negedge clk);
    setSlot(0, 0, 0, 0, 1, 5'd5, 64'h44, 64'hc, 6'd4, 4'd0);
    retire_stall = 1'b1;
    #1;
    chk("lit rf_we after none", 64'(rf_we), 64'd0);
    chk("lit stall rob_pop", 64'(rob_pop), 64'd0);

    // jalr at pc 0x100 in slot 0
    @(negedge clk);
    retire_stall = 1'b0;
    clearHeads();
    setSlot(0, 0, 1, 0, 1, 5'd1, 64'h400, 64'h100, 6'd5, 4'd0);
    setSlot(1, 0, 0, 0, 1, 5'd2, 64'h55, 64'h104, 6'd6, 4'd0);
    #1 chk("lit jalr rob_pop", 64'(rob_pop), 64'd1);
    @(negedge clk);
    clearHeads();
    setSlot(0, 0, 0, 0, 1, 5'd5, 64'h66, 64'h400, 6'd7, 4'd0);
    setSlot(1, 0, 0, 0, 1, 5'd6, 64'h77, 64'h404, 6'd8, 4'd0);
    #1;
    chk("lit jalr rf_we", 64'(rf_we), 64'd1);
    chk("lit jalr link", rf_value[63:0], 64'h104);
    chk("lit jalr flush", 64'(flush), 64'd1);
    chk("lit jalr jump_to", jump_to, 64'h400);
    chk("lit flush rob_pop", 64'(rob_pop), 64'd0);
    @(negedge clk);
    #1;
    chk("lit recover flush", 64'(flush), 64'd0);
    chk("lit recover rob_pop", 64'(rob_pop), 64'd0);
    @(negedge clk);
    #1;
    chk("lit resume rob_pop", 64'(rob_pop), 64'd2);
    chk("lit cnt after jalr", retired_cnt, 64'd3);

    // Back-to-back stores with memory stalled
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      clearHeads();
      st_port.st_ready = 1'b0;
      setSlot(0, 1, 0, 0, 0, 5'd0, 64'h0, 64'h0, 6'(10 + k), 4'd8);
      setSlot(1, 1, 0, 0, 0, 5'd0, 64'h0, 64'h0, 6'd20, 4'd4);
      #1;
      chk("lit store rob_pop", 64'(rob_pop), 64'd1);
      chk("lit store lsq_pop", 64'(lsq_pop), 64'd1);
    end
    @(negedge clk);
    clearHeads();
    setSlot(0, 1, 0, 0, 0, 5'd0, 64'h0, 64'h0, 6'd14, 4'd2);
    st_port.st_ready = 1'b1;
    #1;
    chk("lit full rob_pop", 64'(rob_pop), 64'd0);
    chk("lit full lsq_pop", 64'(lsq_pop), 64'd0);
    chk("lit full st_tag", 64'(st_port.st_tag), 64'd10);
    @(negedge clk);
    #1;
    chk("lit after pop rob_pop", 64'(rob_pop), 64'd1);
    chk("lit drain tag 11", 64'(st_port.st_tag), 64'd11);
    @(negedge clk);
    clearHeads();
    #1 chk("lit drain tag 12", 64'(st_port.st_tag), 64'd12);
    @(negedge clk);
    #1 chk("lit drain tag 13", 64'(st_port.st_tag), 64'd13);
    @(negedge clk);
    #1;
    chk("lit drain tag 14", 64'(st_port.st_tag), 64'd14);
    chk("lit drain size 14", 64'(st_port.st_size), 64'd2);
    @(negedge clk);
    #1 chk("lit drained", 64'(st_port.st_valid), 64'd0);

    // Mispredict while two stores are queued
    @(negedge clk);
    st_port.st_ready = 1'b0;
    clearHeads();
    setSlot(0, 1, 0, 0, 0, 5'd0, 64'h0, 64'h0, 6'd30, 4'd1);
    @(negedge clk);
    setSlot(0, 1, 0, 0, 0, 5'd0, 64'h0, 64'h0, 6'd31, 4'd4);
    @(negedge clk);
    setSlot(0, 0, 0, 1, 0, 5'd0, 64'h800, 64'h200, 6'd32, 4'd0);
    setSlot(1, 0, 0, 0, 1, 5'd7, 64'h99, 64'h204, 6'd33, 4'd0);
    #1 chk("lit mispredict rob_pop", 64'(rob_pop), 64'd1);
    @(negedge clk);
    clearHeads();
    st_port.st_ready = 1'b1;
    #1;
    chk("lit mis flush", 64'(flush), 64'd1);
    chk("lit mis jump_to", jump_to, 64'h800);
    chk("lit mis st_tag", 64'(st_port.st_tag), 64'd30);
    @(negedge clk);
    #1 chk("lit mis st_tag 31", 64'(st_port.st_tag), 64'd31);
    @(negedge clk);
    #1 chk("lit mis drained", 64'(st_port.st_valid), 64'd0);

    // Reset asserted during FLUSH with a store queued
    @(negedge clk);
    st_port.st_ready = 1'b0;
    clearHeads();
    setSlot(0, 1, 0, 0, 0, 5'd0, 64'h0, 64'h0, 6'd40, 4'd2);
    setSlot(1, 0, 0, 1, 0, 5'd0, 64'h900, 64'h300, 6'd41, 4'd0);
    #1;
    chk("lit store+mis rob_pop", 64'(rob_pop), 64'd2);
    chk("lit store+mis lsq_pop", 64'(lsq_pop), 64'd1);
    @(negedge clk);
    clearHeads();
    #1;
    chk("lit pre-reset flush", 64'(flush), 64'd1);
    chk("lit pre-reset st_valid", 64'(st_port.st_valid), 64'd1);
    reset = 1'b0;
    #0.5;
    chk("lit mid-flush reset flush", 64'(flush), 64'd0);
    chk("lit mid-flush reset st_valid", 64'(st_port.st_valid), 64'd0);
    chk("lit mid-flush reset jump_to", jump_to, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    setSlot(0, 0, 0, 0, 1, 5'd8, 64'haa, 64'h0, 6'd42, 4'd0);
    setSlot(1, 0, 0, 0, 1, 5'd9, 64'hbb, 64'h4, 6'd43, 4'd0);
    #1 chk("lit post-reset rob_pop", 64'(rob_pop), 64'd2);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      applyStimulus();
    end
    @(negedge clk);
    clearHeads();
    retire_stall = 1'b0;
    st_port.st_ready = 1'b1;
    repeat (8) @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/retire_wide.md
# retire_wide

Parametrised in-order commit stage that retires up to WIDTH ready ROB head entries per cycle. It writes results to the architectural register file and pops the ROB and LSQ. Retired stores are queued in an internal store-commit FIFO that drains to memory under a valid/ready handshake. Jump/mispredict redirects are sequenced through a small flush state machine. It sits between the ROB/LSQ heads and the register file, data memory port and fetch redirect.

## Interface
- WIDTH, 2: retire slots per cycle (1..4); slot 0 is the oldest ROB entry
- TAG_W, 6: ROB tag width
- XLEN, 64: data/address width
- SQ_DEPTH, 4: store-commit FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- retire_stall  in  1  blocks all retirement this cycle
- head_ready  in  WIDTH  slot i entry valid and completed
- head_tag  in  WIDTH*TAG_W  slot i ROB tag
- head_rd  in  WIDTH*5  slot i destination register
- head_value  in  WIDTH*XLEN  slot i result, or target for jumps/mispredicts
- head_pc  in  WIDTH*XLEN  slot i PC
- head_regwr, head_store, head_jalr, head_mispredict  in  WIDTH each  slot i control bits
- head_st_size  in  WIDTH*4  store bytes (1/2/4/8)
- rob_pop  out  $clog2(WIDTH+1)  entries retired this cycle (combinational)
- lsq_pop  out  1  LSQ head popped this cycle (combinational)
- rf_we  out  WIDTH  registered write enables
- rf_rd  out  WIDTH*5  registered write addresses
- rf_value  out  WIDTH*XLEN  registered write data
- st_valid  out  1  FIFO head valid
- st_ready  in  1  memory accepts store
- st_tag  out  TAG_W  FIFO head tag
- st_size  out  4  FIFO head size
- flush  out  1  one-cycle redirect pulse
- jump_to  out  XLEN  redirect target, valid while flush=1
- retired_cnt  out  64  total instructions retired

## Operation
- Slot i retires iff all of the following hold: state is RUN; retire_stall=0; head_ready[i]=1; slots 0..i-1 all retire; no earlier slot this cycle is a redirect (jalr or mispredict).
- Retirement is strictly a prefix: a non-ready slot blocks every younger slot.
- Stores:
  - At most one store retires per cycle; a second store in the same cycle ends the prefix at that slot.
  - A store retires only if the FIFO is not full at the start of the cycle. Same-cycle pops do not free space.
  - A retiring store sets lsq_pop=1 and pushes {tag, size} into the FIFO.
- Register write for a retiring slot: rf_we[i] = head_regwr[i] && head_rd[i]≠0.
  - rf_value[i] = head_pc[i]+4 if head_jalr[i], else head_value[i].
  - rd=0 never produces a write.
- Redirect: a retiring slot with head_jalr or head_mispredict is the last slot retired that cycle. It latches jump_to=head_value[i] and moves the FSM to FLUSH.
- FSM:
  - RUN → FLUSH on a retired redirect.
  - FLUSH: flush=1 for exactly one cycle, no retirement. → RECOVER.
  - RECOVER: no retirement (ROB/LSQ clear). → RUN.
- Flush does not clear the store FIFO; committed stores always drain.
- The FIFO pops on st_valid && st_ready. st_tag/st_size are stable while st_valid && !st_ready.
- retired_cnt += rob_pop each cycle. It wraps modulo 2^64.

## Timing
- rob_pop and lsq_pop are combinational from the heads, stall and FSM state in the same cycle.
- rf_* outputs are registered, one cycle after the retire decision. rf_we is 0 in any cycle following no retirement.
- flush is asserted the cycle after the redirect retires. Retirement resumes 3 cycles after the redirect cycle (the redirect cycle, then FLUSH, then RECOVER).
- Store latency: st_valid rises the cycle after the push when the FIFO was empty.
- Reset values:
  - rf_we=0, rf_rd=0, rf_value=0
  - st_valid=0, st_tag=0, st_size=0
  - flush=0, jump_to=0
  - retired_cnt=0
  - FIFO empty, FSM=RUN
- Reset mid-flush returns the FSM to RUN and drops queued stores.
- Full FIFO with st_ready=1: the pop occurs, but the store at the ROB head waits one more cycle.
- retire_stall during FLUSH/RECOVER has no effect on the FSM sequence.

## Test plan
- WIDTH=2, both slots ready, regwr, rd=3/rd=0, values 0x11/0x22 → rob_pop=2; next cycle rf_we=01, rf_rd[0]=3, rf_value[0]=0x11.
- Slot 0 not ready, slot 1 ready → rob_pop=0, rf_we=00. Then retire_stall=1 with both ready → rob_pop=0.
- Slot 0 jalr at pc 0x100, value 0x400, rd=1; slot 1 ready → rob_pop=1. Next cycle rf_value=0x104, flush=1, jump_to=0x400. Following cycle no retire. Retirement resumes after that.
- Two stores in slots 0/1 with st_ready=0 → one store per cycle. Once 4 stores are queued, a further store stalls (rob_pop=0) until st_ready=1 pops one; tags drain in order.
- Mispredict retires while the FIFO holds 2 stores → flush pulse; both stores still drain with correct tags.
- Assert reset low during FLUSH → all outputs at reset values, FSM=RUN. Retirement occurs on the first cycle after reset deasserts.
